// File: rtl/wb_stage.sv
// wb_stage: write-back source select, load extension and 32x32 bypassing register file.
// Define WB_TRACE_EN to print one trace line per committed register write.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC4_W,
    input  logic [31:0] IR_W,
    input  logic [31:0] ALUOut_W,
    input  logic [31:0] imm_W,
    input  logic [31:0] DR_W,
    input  logic [4:0]  WA_W,
    input  logic [31:0] HI_W,
    input  logic [31:0] LO_W,
    input  logic        RegWrite_W,
    input  logic [2:0]  MemtoReg_W,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WD_W
);
    logic [31:0] r_rf [32];
    logic [31:0] w_sh;
    logic [31:0] w_ld;
    logic [15:0] w_h;
    logic [5:0]  w_op;
    logic        w_we;
    logic        w_unused;

    assign w_op     = IR_W[31:26];
    assign w_sh     = DR_W >> {ALUOut_W[1:0], 3'b000};
    assign w_h      = ALUOut_W[1] ? DR_W[31:16] : DR_W[15:0];
    assign w_we     = RegWrite_W && (WA_W != 5'd0);
    assign w_unused = ^IR_W[25:0];

    always_comb begin
        w_ld = (w_op == 6'b100000) ? {{24{w_sh[7]}}, w_sh[7:0]} :
               (w_op == 6'b100100) ? {24'd0, w_sh[7:0]} :
               (w_op == 6'b100001) ? {{16{w_h[15]}}, w_h} :
               (w_op == 6'b100101) ? {16'd0, w_h} : DR_W;
    end

    always_comb begin
        WD_W = (MemtoReg_W == 3'd1) ? w_ld :
               (MemtoReg_W == 3'd2) ? PC4_W + 32'd4 :
               (MemtoReg_W == 3'd3) ? HI_W :
               (MemtoReg_W == 3'd4) ? LO_W :
               (MemtoReg_W == 3'd5) ? imm_W : ALUOut_W;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_we) begin
            r_rf[WA_W] <= WD_W;
        end
    end

    // Bypass keeps the decode stage coherent with the write landing this cycle.
    always_comb begin
        RD1 = (RA1 == 5'd0) ? 32'd0 : (w_we && RA1 == WA_W) ? WD_W : r_rf[RA1];
        RD2 = (RA2 == 5'd0) ? 32'd0 : (w_we && RA2 == WA_W) ? WD_W : r_rf[RA2];
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && w_we) $display("@%h: $%0d <= %h", PC4_W - 32'd4, WA_W, WD_W);
    end
`else
`endif
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL provide port clk, input, 1, single clock, all state updates on rising edge.
REQ-002 The block SHALL provide port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-003 The block SHALL provide port PC4_W, input, 32, PC+4 of the retiring instruction.
REQ-004 The block SHALL provide port IR_W, input, 32, instruction word of the retiring instruction.
REQ-005 The block SHALL provide port ALUOut_W, input, 32, ALU result, also the load address.
REQ-006 The block SHALL provide port imm_W, input, 32, pre-shifted/extended immediate.
REQ-007 The block SHALL provide port DR_W, input, 32, raw data-memory word.
REQ-008 The block SHALL provide port WA_W, input, 5, destination register number.
REQ-009 The block SHALL provide ports HI_W and LO_W, input, 32 each, HI/LO register values.
REQ-010 The block SHALL provide port RegWrite_W, input, 1, register write enable.
REQ-011 The block SHALL provide port MemtoReg_W, input, 3, write-back source select.
REQ-012 The block SHALL provide ports RA1 and RA2, input, 5 each, decode-stage read addresses.
REQ-013 The block SHALL provide ports RD1 and RD2, output, 32 each, read data.
REQ-014 The block SHALL provide port WD_W, output, 32, selected write-back data for forwarding.

Function
REQ-015 The block SHALL select WD_W by MemtoReg_W: 0 ALUOut_W; 1 extended load data; 2 PC4_W+4; 3 HI_W; 4 LO_W; 5 imm_W; 6-7 ALUOut_W.
- Link value: PC4_W+4, mod 2^32.
REQ-016 The block SHALL extend load data by IR_W[31:26] and byte offset ALUOut_W[1:0]:
- 100011 lw: DR_W.
- 100000 lb / 100100 lbu: byte DR_W[8*off+7:8*off], sign/zero extended.
- 100001 lh / 100101 lhu: half selected by ALUOut_W[1], sign/zero extended.
- Any other opcode: DR_W unchanged.
REQ-017 The block SHALL hold a 32x32 register file; register 0 reads 0 always and is never written.
REQ-018 The block SHALL write WD_W into register WA_W on the rising clk edge when reset=1, RegWrite_W=1 and WA_W!=0.
REQ-019 The block SHALL drive RD1/RD2 combinationally with 0-cycle read latency.
REQ-020 The block SHALL bypass writes: when RAx==WA_W, WA_W!=0 and RegWrite_W=1, RDx SHALL equal WD_W in the same cycle.
- The bypass SHALL apply to both ports simultaneously when RA1==RA2==WA_W.
REQ-021 The block SHALL have write-before-read semantics, so a value written at edge N is visible on RDx after edge N without bypass.
REQ-022 The block SHALL ignore WA_W=0 writes completely, including the bypass; RDx for RAx=0 SHALL be 0.

Reset
REQ-023 The block SHALL clear registers 1-31 to 0 immediately on reset falling to 0, without waiting for clk.
REQ-024 The block SHALL suppress writes during reset=0 and SHALL give RD1/RD2 = 0 for unbypassed reads during reset.
REQ-025 The block SHALL leave WD_W purely combinational on its inputs; WD_W has no reset value.
REQ-026 The block SHALL accept writes from the first rising edge after reset returns to 1.
REQ-027 The block SHALL discard a write coinciding with reset assertion mid-operation.

Configuration
REQ-028 The block SHALL compile a write trace when macro WB_TRACE_EN is defined.
- Defined: on each committed write, print "@<PC4_W-4 hex>: $<WA_W dec> <= <WD_W hex>" via $display at that edge.
- Not defined: no trace logic, identical register behaviour.

Verification
REQ-029 Reset test: write 0x12345678 to $5, assert reset=0 between edges -> RD1(RA1=5) reads 0 before the next edge.
REQ-030 Load-extension test: DR_W=0x80FF7F01, lb, ALUOut_W[1:0]=3 -> WD_W=0xFFFFFF80; lbu off=1 -> 0x0000007F; lh off=2 -> 0xFFFF80FF; lhu off=2 -> 0x000080FF.
REQ-031 Bypass test: RegWrite_W=1, WA_W=7, MemtoReg_W=0, ALUOut_W=0xDEADBEEF, RA1=RA2=7 -> RD1=RD2=0xDEADBEEF before the edge and after it.
REQ-032 $0 test: RegWrite_W=1, WA_W=0, ALUOut_W=0xFFFFFFFF, RA1=0 -> RD1=0 before and after the edge.
REQ-033 Source-mux test: MemtoReg_W=2, PC4_W=0x00003004 -> WD_W=0x00003008; MemtoReg_W=3/4 -> WD_W=HI_W/LO_W; MemtoReg_W=7 -> ALUOut_W.
REQ-034 Trace test with WB_TRACE_EN defined: PC4_W=0x00003010, WA_W=2, WD_W=0x1 -> one line "@0000300c: $2 <= 00000001".
